af_stream_ctrl: RTL

//  Streaming front/back end for the cordic activation unit (hyperbolic pipeline + divider, 24-cycle path).

---
 rtl/af_stream_ctrl.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/af_stream_ctrl.sv
// af_stream_ctrl: ready/valid front end and in-order output buffer for the
// cordic activation unit. The cordic pipeline cannot stall, so work is only
// issued when the output FIFO is guaranteed to have room for its result.
module af_stream_ctrl #(
    parameter int unsigned LAT   = 24,
    parameter int unsigned DEPTH = 32,
    parameter int unsigned CW    = 6
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [15:0]   in_data,
    input  logic          in_sig,
    input  logic          in_relu,
    input  logic          cfg_simd,
    input  logic          cfg_shift_mode,
    output logic [15:0]   af_in,
    output logic          af_sig_or_tan,
    output logic          af_relu_or_cordic,
    output logic          af_simd_sel,
    output logic          af_shift_mode,
    input  logic [15:0]   af_out_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [15:0]   out_data,
    output logic [CW-1:0] out_count,
    output logic          busy
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned SW = CW + 1;

    logic [LAT-1:0] vld_q, vld_d;
    logic [CW-1:0]  inflight_q, inflight_d;
    logic [CW-1:0]  count_q, count_d;
    logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
    logic           sig_q, sig_d;
    logic           simd_q, simd_d;
    logic           shift_q, shift_d;
    logic [15:0]    mem_q [DEPTH];
    logic [15:0]    mem_d [DEPTH];

    logic mode_match_c;
    logic credit_ok_c;
    logic accept_c;
    logic relu_acc_c;
    logic cordic_acc_c;
    logic tag_exit_c;
    logic wr_en_c;
    logic pop_c;

    // Issue gating: credit against registered occupancy, and mode changes or relu only on an empty pipe
    always_comb begin
        mode_match_c = ({in_sig, cfg_simd, cfg_shift_mode} == {sig_q, simd_q, shift_q});
        credit_ok_c  = (SW'(count_q) + SW'(inflight_q)) < SW'(DEPTH);
        in_ready     = rst & credit_ok_c & ((inflight_q == '0) | (~in_relu & mode_match_c));
        accept_c     = in_valid & in_ready;
        relu_acc_c   = accept_c & in_relu;
        cordic_acc_c = accept_c & ~in_relu;
        tag_exit_c   = vld_q[LAT-1];
        wr_en_c      = tag_exit_c | relu_acc_c;
        pop_c        = out_valid & out_ready;
    end

    // Next state: valid delay line, in-flight count, FIFO storage/pointers, mode registers
    always_comb begin
        vld_d      = {vld_q[LAT-2:0], cordic_acc_c};
        inflight_d = inflight_q;
        count_d    = count_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        sig_d      = sig_q;
        simd_d     = simd_q;
        shift_d    = shift_q;
        mem_d      = mem_q;

        if (cordic_acc_c && !tag_exit_c) begin
            inflight_d = inflight_q + CW'(1);
        end else if (!cordic_acc_c && tag_exit_c) begin
            inflight_d = inflight_q - CW'(1);
        end

        if (wr_en_c) begin
            mem_d[wr_ptr_q] = af_out_data;
            wr_ptr_d = (wr_ptr_q == PW'(DEPTH - 1)) ? '0 : wr_ptr_q + PW'(1);
        end

        if (pop_c) begin
            rd_ptr_d = (rd_ptr_q == PW'(DEPTH - 1)) ? '0 : rd_ptr_q + PW'(1);
        end

        case ({wr_en_c, pop_c})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        if (accept_c) begin
            sig_d   = in_sig;
            simd_d  = cfg_simd;
            shift_d = cfg_shift_mode;
        end
    end

    // Control state; reset drops everything in flight or buffered
    always_ff @(posedge clk) begin
        if (!rst) begin
            vld_q      <= '0;
            inflight_q <= '0;
            count_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            sig_q      <= 1'b0;
            simd_q     <= 1'b0;
            shift_q    <= 1'b0;
        end else begin
            vld_q      <= vld_d;
            inflight_q <= inflight_d;
            count_q    <= count_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            sig_q      <= sig_d;
            simd_q     <= simd_d;
            shift_q    <= shift_d;
        end
    end

    // FIFO storage; contents are only meaningful behind the occupancy count
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign af_in             = in_data;
    assign af_relu_or_cordic = relu_acc_c;
    assign af_sig_or_tan     = sig_q;
    assign af_simd_sel       = simd_q;
    assign af_shift_mode     = shift_q;
    assign out_valid         = (count_q != '0);
    assign out_data          = mem_q[rd_ptr_q];
    assign out_count         = count_q;
    assign busy              = (inflight_q != '0) | out_valid;

    // Conditions the issue rules make unreachable
    a_no_relu_tag_collision: assert property (@(posedge clk) disable iff (!rst)
        !(relu_acc_c && tag_exit_c));
    a_no_overflow: assert property (@(posedge clk) disable iff (!rst)
        !(wr_en_c && !pop_c && (count_q == CW'(DEPTH))));
    a_inflight_range: assert property (@(posedge clk) disable iff (!rst)
        inflight_q <= CW'(LAT));

endmodule
